// File: rtl/exc_ctrl_if.sv
// Handshake/bus bundle between the MEM stage, CP0 and the exception sequencer.
// master drives the MEM/CP0/WB/fetch side; slave is the sequencer itself.
interface exc_ctrl_if #(
  parameter int CNT_W = 16
);
  logic              mem_valid_i;
  logic [4:0]        mem_exc_i;
  logic [31:0]       mem_pc_i;
  logic              mem_in_delayslot_i;
  logic [31:0]       cp0_status_i;
  logic [31:0]       cp0_cause_i;
  logic [31:0]       cp0_epc_i;
  logic              wb_cp0_we_i;
  logic [4:0]        wb_cp0_waddr_i;
  logic [31:0]       wb_cp0_data_i;
  logic              if_ready_i;
  logic [31:0]       excepttype_o;
  logic [31:0]       cur_inst_addr_o;
  logic              is_in_delayslot_o;
  logic              flush_o;
  logic              stall_o;
  logic              redirect_valid_o;
  logic [31:0]       new_pc_o;
  logic [CNT_W-1:0]  exc_count_o;

  modport master (
    output mem_valid_i, mem_exc_i, mem_pc_i,
    output mem_in_delayslot_i,
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    output wb_cp0_we_i, wb_cp0_waddr_i,
    output wb_cp0_data_i, if_ready_i,
    input  excepttype_o, cur_inst_addr_o,
    input  is_in_delayslot_o, flush_o, stall_o,
    input  redirect_valid_o, new_pc_o,
    input  exc_count_o
  );

  modport slave (
    input  mem_valid_i, mem_exc_i, mem_pc_i,
    input  mem_in_delayslot_i,
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  wb_cp0_we_i, wb_cp0_waddr_i,
    input  wb_cp0_data_i, if_ready_i,
    output excepttype_o, cur_inst_addr_o,
    output is_in_delayslot_o, flush_o, stall_o,
    output redirect_valid_o, new_pc_o,
    output exc_count_o
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: arbitrates MEM exception sources,
// pulses the code to CP0, flushes and holds a redirect PC for fetch.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int          CNT_W      = 16
) (
  input  logic   clk,
  input  logic   rst,
  exc_ctrl_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_REDIR
  } state_e;

  localparam logic [31:0] C_INT  = 32'h1;
  localparam logic [31:0] C_SYS  = 32'h8;
  localparam logic [31:0] C_RI   = 32'ha;
  localparam logic [31:0] C_TRAP = 32'hd;
  localparam logic [31:0] C_OVF  = 32'hc;
  localparam logic [31:0] C_ERET = 32'he;

  state_e           state_q, state_d;
  logic [31:0]      new_pc_q, new_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        wb_status;
  logic        wb_cause;
  logic        wb_epc;
  logic [31:0] status_e;
  logic [31:0] cause_e;
  logic [31:0] epc_e;
  logic        irq;
  logic [31:0] code;
  logic        take;

  // In-flight mtc0 in WB overrides the stale CP0 values.
  assign wb_status = bus.wb_cp0_we_i
                   && (bus.wb_cp0_waddr_i == 5'd12);
  assign wb_cause  = bus.wb_cp0_we_i
                   && (bus.wb_cp0_waddr_i == 5'd13);
  assign wb_epc    = bus.wb_cp0_we_i
                   && (bus.wb_cp0_waddr_i == 5'd14);

  assign status_e = wb_status ? bus.wb_cp0_data_i
                              : bus.cp0_status_i;
  assign cause_e  = wb_cause
                  ? {bus.cp0_cause_i[31:10],
                     bus.wb_cp0_data_i[9:8],
                     bus.cp0_cause_i[7:0]}
                  : bus.cp0_cause_i;
  assign epc_e    = wb_epc ? bus.wb_cp0_data_i
                           : bus.cp0_epc_i;

  assign irq = status_e[0] && !status_e[1]
            && ((cause_e[15:8] & status_e[15:8]) != 8'h0);

  always_comb begin
    code = 32'h0;
    if (irq)                   code = C_INT;
    else if (bus.mem_exc_i[0]) code = C_SYS;
    else if (bus.mem_exc_i[1]) code = C_RI;
    else if (bus.mem_exc_i[2]) code = C_TRAP;
    else if (bus.mem_exc_i[3]) code = C_OVF;
    else if (bus.mem_exc_i[4]) code = C_ERET;
  end

  // rst gating keeps the combinational pulse quiet during reset.
  assign take = rst
             && (state_q == S_IDLE)
             && bus.mem_valid_i
             && (code != 32'h0);

  always_comb begin
    state_d  = state_q;
    new_pc_d = new_pc_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d  = S_REDIR;
          new_pc_d = (code == C_ERET) ? epc_e
                                      : EXC_VECTOR;
          if ((code != C_ERET) && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
        end
      end
      S_REDIR: begin
        if (bus.if_ready_i)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      new_pc_q <= 32'h0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      new_pc_q <= new_pc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.excepttype_o      = take ? code : 32'h0;
  assign bus.flush_o           = take;
  assign bus.cur_inst_addr_o   = bus.mem_pc_i;
  assign bus.is_in_delayslot_o = bus.mem_in_delayslot_i;
  assign bus.redirect_valid_o  = (state_q == S_REDIR);
  assign bus.stall_o           = (state_q == S_REDIR);
  assign bus.new_pc_o          = new_pc_q;
  assign bus.exc_count_o       = cnt_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomized + directed bench for exc_ctrl against a behavioural model.
module tb_exc_ctrl;

  logic clk;
  logic rst;

  exc_ctrl_if #(.CNT_W(16)) bus ();
  exc_ctrl_if #(.CNT_W(2))  bus2 ();

  exc_ctrl #(.EXC_VECTOR(32'h20), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exc_ctrl #(.EXC_VECTOR(32'h20), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Behavioural model: redirect pending flag, target PC, count.
  bit          m_redir;
  logic [31:0] m_pc;
  int          m_cnt;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] eff_status();
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 12)
      return bus.wb_cp0_data_i;
    return bus.cp0_status_i;
  endfunction

  function automatic logic [31:0] eff_cause();
    logic [31:0] c;
    c = bus.cp0_cause_i;
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 13) begin
      c[9] = bus.wb_cp0_data_i[9];
      c[8] = bus.wb_cp0_data_i[8];
    end
    return c;
  endfunction

  function automatic logic [31:0] eff_epc();
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 14)
      return bus.wb_cp0_data_i;
    return bus.cp0_epc_i;
  endfunction

  function automatic logic [31:0] ref_code();
    logic [31:0] s, c;
    bit pend;
    s = eff_status();
    c = eff_cause();
    pend = 1'b0;
    for (int i = 8; i < 16; i++)
      if (s[i] && c[i]) pend = 1'b1;
    if (!rst || m_redir || !bus.mem_valid_i) return 0;
    if (s[0] && !s[1] && pend)  return 32'h1;
    if (bus.mem_exc_i[0])       return 32'h8;
    if (bus.mem_exc_i[1])       return 32'ha;
    if (bus.mem_exc_i[2])       return 32'hd;
    if (bus.mem_exc_i[3])       return 32'hc;
    if (bus.mem_exc_i[4])       return 32'he;
    return 0;
  endfunction

  task automatic model_reset();
    m_redir = 0;
    m_pc    = 0;
    m_cnt   = 0;
  endtask

  task automatic check_regs();
    check("redir", {31'b0, bus.redirect_valid_o},
          {31'b0, m_redir});
    check("stall", {31'b0, bus.stall_o}, {31'b0, m_redir});
    check("newpc", bus.new_pc_o, m_pc);
    check("cnt", {16'b0, bus.exc_count_o}, m_cnt);
  endtask

  // Called just after a negedge with inputs driven; returns at next negedge.
  task automatic tick();
    logic [31:0] ec;
    logic [31:0] epc;
    ec  = ref_code();
    epc = eff_epc();
    #2;
    check("code", bus.excepttype_o, ec);
    check("flush", {31'b0, bus.flush_o}, {31'b0, ec != 0});
    check("curpc", bus.cur_inst_addr_o, bus.mem_pc_i);
    check("dslot", {31'b0, bus.is_in_delayslot_o},
          {31'b0, bus.mem_in_delayslot_i});
    check_regs();
    @(posedge clk);
    if (ec != 0) begin
      m_redir = 1;
      m_pc    = (ec == 32'he) ? epc : 32'h20;
      if (ec != 32'he && m_cnt < 65535) m_cnt++;
    end else if (m_redir && bus.if_ready_i) begin
      m_redir = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.mem_valid_i        = 0;
    bus.mem_exc_i          = 0;
    bus.mem_pc_i           = 0;
    bus.mem_in_delayslot_i = 0;
    bus.cp0_status_i       = 0;
    bus.cp0_cause_i        = 0;
    bus.cp0_epc_i          = 0;
    bus.wb_cp0_we_i        = 0;
    bus.wb_cp0_waddr_i     = 0;
    bus.wb_cp0_data_i      = 0;
    bus.if_ready_i         = 0;
  endtask

  task automatic drain();
    idle_inputs();
    bus.if_ready_i = 1;
    for (int i = 0; i < 4 && m_redir; i++) tick();
    bus.if_ready_i = 0;
  endtask

  logic [31:0] cnt_before;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    idle_inputs();
    bus2.mem_valid_i        = 0;
    bus2.mem_exc_i          = 0;
    bus2.mem_pc_i           = 0;
    bus2.mem_in_delayslot_i = 0;
    bus2.cp0_status_i       = 0;
    bus2.cp0_cause_i        = 0;
    bus2.cp0_epc_i          = 0;
    bus2.wb_cp0_we_i        = 0;
    bus2.wb_cp0_waddr_i     = 0;
    bus2.wb_cp0_data_i      = 0;
    bus2.if_ready_i         = 0;
    rst = 0;
    bus.mem_valid_i = 1;
    bus.mem_exc_i   = 5'h1;
    repeat (2) @(negedge clk);
    check("rst_code", bus.excepttype_o, 0);
    check("rst_flush", {31'b0, bus.flush_o}, 0);
    check_regs();
    idle_inputs();
    rst = 1;

    // syscall at 0x100
    bus.mem_valid_i = 1;
    bus.mem_exc_i   = 5'h01;
    bus.mem_pc_i    = 32'h100;
    #1;
    check("sys_code", bus.excepttype_o, 32'h8);
    check("sys_pc", bus.cur_inst_addr_o, 32'h100);
    tick();
    idle_inputs();
    #1;
    check("sys_rv", {31'b0, bus.redirect_valid_o}, 1);
    check("sys_npc", bus.new_pc_o, 32'h20);
    check("sys_cnt", {16'b0, bus.exc_count_o}, 1);
    tick();
    drain();

    // interrupt beats syscall+ovf; masked by EXL it does not
    bus.mem_valid_i  = 1;
    bus.mem_exc_i    = 5'b01001;
    bus.cp0_status_i = 32'h0000_0401;
    bus.cp0_cause_i  = 32'h0000_0400;
    #1;
    check("irq_code", bus.excepttype_o, 32'h1);
    tick();
    drain();
    bus.mem_valid_i  = 1;
    bus.mem_exc_i    = 5'b01001;
    bus.cp0_status_i = 32'h0000_0403;
    bus.cp0_cause_i  = 32'h0000_0400;
    #1;
    check("exl_code", bus.excepttype_o, 32'h8);
    tick();
    drain();

    // eret with EPC bypass
    cnt_before = {16'b0, bus.exc_count_o};
    bus.mem_valid_i    = 1;
    bus.mem_exc_i      = 5'h10;
    bus.cp0_epc_i      = 32'h200;
    bus.wb_cp0_we_i    = 1;
    bus.wb_cp0_waddr_i = 5'd14;
    bus.wb_cp0_data_i  = 32'h300;
    #1;
    check("eret_code", bus.excepttype_o, 32'he);
    tick();
    idle_inputs();
    #1;
    check("eret_npc", bus.new_pc_o, 32'h300);
    check("eret_cnt", {16'b0, bus.exc_count_o}, cnt_before);
    drain();

    // fetch stalls 3 cycles with ri pending, then back-to-back take
    bus.mem_valid_i = 1;
    bus.mem_exc_i   = 5'h01;
    tick();
    bus.mem_exc_i   = 5'h02;
    for (int i = 0; i < 4; i++) begin
      bus.if_ready_i = (i == 3);
      #1;
      check("hold_stall", {31'b0, bus.stall_o}, 1);
      check("hold_code", bus.excepttype_o, 0);
      check("hold_npc", bus.new_pc_o, 32'h20);
      tick();
    end
    bus.if_ready_i = 0;
    #1;
    check("b2b_code", bus.excepttype_o, 32'ha);
    tick();
    drain();

    // bypassed Status write clears IE: no interrupt
    bus.mem_valid_i    = 1;
    bus.cp0_status_i   = 32'h0000_0401;
    bus.cp0_cause_i    = 32'h0000_0400;
    bus.wb_cp0_we_i    = 1;
    bus.wb_cp0_waddr_i = 5'd12;
    bus.wb_cp0_data_i  = 32'h0000_0400;
    #1;
    check("ie_clr", bus.excepttype_o, 0);
    tick();
    idle_inputs();

    // reset in the middle of a redirect
    bus.mem_valid_i = 1;
    bus.mem_exc_i   = 5'h04;
    tick();
    bus.mem_exc_i   = 5'h01;
    #1;
    rst = 0;
    #1;
    check("mid_rv", {31'b0, bus.redirect_valid_o}, 0);
    check("mid_stall", {31'b0, bus.stall_o}, 0);
    check("mid_code", bus.excepttype_o, 0);
    check("mid_flush", {31'b0, bus.flush_o}, 0);
    check("mid_npc", bus.new_pc_o, 0);
    check("mid_cnt", {16'b0, bus.exc_count_o}, 0);
    model_reset();
    @(negedge clk);
    rst = 1;
    #1;
    check("post_code", bus.excepttype_o, 32'h8);
    tick();
    drain();

    // 2-bit counter saturation on the second instance
    for (int i = 0; i < 4; i++) begin
      bus2.mem_valid_i = 1;
      bus2.mem_exc_i   = 5'h01;
      bus2.if_ready_i  = 0;
      tick();
      check("sat_cnt", {30'b0, bus2.exc_count_o},
            (i < 3) ? i + 1 : 3);
      bus2.mem_exc_i  = 0;
      bus2.if_ready_i = 1;
      tick();
    end
    bus2.mem_valid_i = 0;
    bus2.if_ready_i  = 0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.mem_valid_i        = ($urandom_range(0, 9) < 8);
      bus.mem_exc_i          = ($urandom_range(0, 9) < 4)
                             ? 5'($urandom_range(1, 31)) : 5'h0;
      bus.mem_pc_i           = $urandom & 32'hffff_fffc;
      bus.mem_in_delayslot_i = 1'($urandom_range(0, 1));
      bus.cp0_status_i       = $urandom & 32'h0000_ff03;
      bus.cp0_cause_i        = ($urandom_range(0, 3) == 0)
                             ? ($urandom & 32'h0000_ff00) : 32'h0;
      bus.cp0_epc_i          = $urandom;
      bus.wb_cp0_we_i        = ($urandom_range(0, 3) == 0);
      bus.wb_cp0_waddr_i     = 5'($urandom_range(11, 15));
      bus.wb_cp0_data_i      = $urandom;
      bus.if_ready_i         = 1'($urandom_range(0, 1));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt sequencer between the MEM stage and the CP0 register block. It arbitrates the pending exception sources of the instruction in MEM, including masked external interrupts. It emits a one-cycle exception code, faulting PC and delay-slot flag to CP0, and flushes the pipeline. It then holds a redirect PC (exception vector or EPC for eret) until fetch accepts it. In-flight CP0 writes from WB are bypassed so that decisions always use up-to-date Status/Cause/EPC.

## Interface
Parameters:
- EXC_VECTOR, 32'h00000020, handler entry PC for all non-eret exceptions
- CNT_W, 16, width of the saturating exception counter

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- mem_valid_i  in  1  MEM stage holds a real (non-bubble) instruction
- mem_exc_i  in  5  source flags {eret, ovf, trap, ri, syscall}, bit4..bit0
- mem_pc_i  in  32  PC of MEM instruction
- mem_in_delayslot_i  in  1  MEM instruction is in a delay slot
- cp0_status_i / cp0_cause_i / cp0_epc_i  in  32 each  current CP0 register values
- wb_cp0_we_i  in  1  mtc0 write pending in WB
- wb_cp0_waddr_i  in  5  its CP0 register number
- wb_cp0_data_i  in  32  its data
- if_ready_i  in  1  fetch accepts redirect this cycle
- excepttype_o  out  32  exception code to CP0; 0 = none
- cur_inst_addr_o  out  32  faulting PC to CP0 (= mem_pc_i)
- is_in_delayslot_o  out  1  to CP0 (= mem_in_delayslot_i)
- flush_o  out  1  flush IF..MEM
- stall_o  out  1  stall pipeline while redirect pending
- redirect_valid_o  out  1  new_pc_o is valid
- new_pc_o  out  32  redirect target
- exc_count_o  out  CNT_W  number of exceptions taken, saturating

## Operation
- Effective registers are bypassed from WB:
  - status_e = wb_cp0_data_i if wb_cp0_we_i && waddr==12, else cp0_status_i.
  - cause_e = cp0_cause_i with bits[9:8] replaced by wb data if wb_cp0_we_i && waddr==13.
  - epc_e = wb data if wb_cp0_we_i && waddr==14, else cp0_epc_i.
- Interrupt pending: status_e[0]==1 && status_e[1]==0 && (cause_e[15:8] & status_e[15:8]) != 0.
- Arbitration applies only in IDLE with mem_valid_i=1. Fixed priority, highest first; exactly one code is emitted:
  - interrupt 32'h1
  - syscall 32'h8
  - ri 32'ha
  - trap 32'hd
  - ovf 32'hc
  - eret 32'he
- FSM states: IDLE, REDIRECT.
  - IDLE, code selected:
    - excepttype_o = code and flush_o = 1, both combinational, in the same cycle.
    - new_pc_o latched: epc_e if code == 32'he, else EXC_VECTOR.
    - exc_count_o increments (not for eret); it saturates at all-ones.
    - Next state REDIRECT.
  - IDLE, no code: all control outputs 0; stay in IDLE.
  - REDIRECT:
    - redirect_valid_o = 1, stall_o = 1, excepttype_o = 0, flush_o = 0.
    - New sources are ignored.
    - If if_ready_i = 1, go to IDLE at the next edge; otherwise hold new_pc_o unchanged.
- cur_inst_addr_o and is_in_delayslot_o always pass through from MEM. CP0 ignores them when excepttype_o = 0.
- mem_exc_i with mem_valid_i = 0 is ignored.

## Timing
- Reset (rst = 0, asynchronous): state IDLE, new_pc_o = 0, exc_count_o = 0, redirect_valid_o = 0, stall_o = 0. Combinational outputs are forced 0: excepttype_o = 0, flush_o = 0.
- Detection cycle T:
  - excepttype_o and flush_o are high during T only.
  - CP0 captures the exception at the edge ending T.
- Redirect window:
  - redirect_valid_o and stall_o rise at T+1.
  - They stay high through the first cycle with if_ready_i = 1, then fall at the next edge.
  - Minimum redirect length: 1 cycle. Minimum spacing between two excepttype_o pulses: 2 cycles.
- Back-to-back: an exception in MEM during the cycle the FSM returns to IDLE is taken normally in that cycle.
- WB mtc0 Status that clears IE in the same cycle as an interrupt: the interrupt is not taken (bypass wins).
- Reset asserted during REDIRECT: the redirect is dropped immediately; no pulse is emitted afterwards.

## Test plan
- Syscall, not in delay slot, PC = 0x100 -> excepttype_o = 0x8 for 1 cycle with flush_o = 1, cur_inst_addr_o = 0x100; next cycle redirect_valid_o = 1, new_pc_o = 0x20; exc_count_o = 1.
- Flags syscall+ovf+interrupt together (Status = 0x0000_0401, Cause[10] = 1) -> code 0x1 only; the same setup with Status[1] = 1 -> code 0x8.
- Eret with cp0_epc_i = 0x200 and WB writing EPC = 0x300 in the same cycle -> code 0xe, new_pc_o = 0x300, exc_count_o unchanged.
- if_ready_i low for 3 cycles after a redirect, with ri flagged in MEM meanwhile -> new_pc_o held, stall_o high 4 cycles, no second pulse.
- rst pulled low mid-REDIRECT -> all outputs 0 immediately; after release, the next exception is handled normally.
- CNT_W = 2, four exceptions -> exc_count_o sequence 1, 2, 3, 3.
